hyperbus_delay_ctrl: RTL and testbench
======================================

// Module: hyperbus_delay_ctrl
// PURPOSE
//  Sequences glitch-free reconfiguration of the HyperBus PHY's programmable clock delay line.
//  Accepts a new tap setting over a valid/ready port from the config registers or the training logic.
//  Waits for the PHY to go idle, then gates the delay line, switches taps, waits for it to settle and re-enables it.
//  Sits between the config/training logic and the delay-line instance; drives that instance's enable and delay inputs.
// PARAMETERS
//  DelayWidth    4                   tap-select width of the delay line
//  MaxDelay      2**DelayWidth-1     highest legal tap; larger requests are clamped
//  ResetDelay    0                   tap value driven out of reset
//  GateCycles    2                   cycles (>=1) the line is gated before the tap changes
//  SettleCycles  8                   cycles (>=1) the line stays gated after the tap changes
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           asynchronous reset, active low
//  cfg_valid_i    in   1           new tap request
//  cfg_ready_o    out  1           request accepted when valid&ready
//  cfg_delay_i    in   DelayWidth  requested tap
//  phy_idle_i     in   1           PHY has no transfer in flight
//  delay_en_o     out  1           enable to the delay line
//  delay_o        out  DelayWidth  tap select to the delay line
//  busy_o         out  1           reconfiguration in progress
//  done_o         out  1           one-cycle pulse when a request completes
//  clamped_o      out  1           sticky: a request exceeded MaxDelay; cleared by the next in-range accept
// BEHAVIOUR
//  Reset (async): state IDLE; delay_o=ResetDelay; delay_en_o=1; busy_o=0; done_o=0; clamped_o=0.
//  Reset (async): cfg_ready_o=1 from the first cycle after reset is released.
//  Register and handshake rules:
//   - All outputs are registered, except cfg_ready_o = (state==IDLE).
//   - A requester holds cfg_valid_i and cfg_delay_i stable until ready; accepts happen only in IDLE.
//  On accept: pending <= min(cfg_delay_i, MaxDelay); clamped_o <= (cfg_delay_i > MaxDelay).
//   - If pending == delay_o: no gating; done_o pulses on the next cycle and the FSM stays in IDLE.
//   - Otherwise: state <= WAIT_IDLE and busy_o <= 1.
//  FSM:
//   - IDLE -> WAIT_IDLE on accept with a changed tap.
//   - WAIT_IDLE -> GATE on an edge with phy_idle_i=1; delay_en_o <= 0 at that edge. There is no timeout.
//   - GATE lasts GateCycles cycles; at the exiting edge delay_o <= pending; -> SETTLE.
//   - SETTLE lasts SettleCycles cycles; at the exiting edge delay_en_o <= 1, done_o <= 1, busy_o <= 0; -> IDLE.
//  Latency from the accept edge E0 with phy_idle_i=1 (defaults): en falls @E1, delay_o changes @E3, en rises with done @E11.
//  In general, delay_en_o is low for exactly GateCycles+SettleCycles cycles per update.
//  delay_o only ever changes while delay_en_o=0. delay_en_o never toggles outside GATE/SETTLE entry and exit.
//  phy_idle_i dropping during GATE/SETTLE is ignored: the sequence always runs to completion.
//  A new cfg_valid_i during busy stalls (ready=0); no queueing.
//  Counter: one down-counter of width $clog2(max(GateCycles,SettleCycles)+1).
//   - Loaded on GATE/SETTLE entry; no wrap; unused bits are zero.
//  Reset mid-sequence: immediately back to ResetDelay with en=1; the pending request is dropped and no done_o is issued.
// STRUCTURE
//  hyperbus_delay_pkg: state enum (IDLE, WAIT_IDLE, GATE, SETTLE); delay_t typedef is parameterised in the module.
//  Single module with an inline FSM and counter; no sub-module. The delay-line instance stays in the PHY.
// TESTING
//  1 Reset with defaults -> delay_o=0, delay_en_o=1, cfg_ready_o=1, busy_o=0, done_o=0.
//  2 Request tap 5, phy_idle_i=1 -> en low for 10 cycles; delay_o=5 at E3; done_o only at E11.
//  3 Request tap 5 with phy_idle_i=0 for 20 cycles -> en stays 1, busy=1, delay_o=0; the sequence starts at the first idle edge.
//  4 Request the current tap -> done_o the next cycle, en never drops, busy_o stays 0.
//  5 MaxDelay=9, request 15 -> delay_o=9, clamped_o=1; a later request of 3 clears clamped_o.
//  6 Assert rst_ni low during SETTLE -> delay_o=ResetDelay and en=1 asynchronously; no done_o after release.

Source files
------------

// File: rtl/hyperbus_delay_ctrl_pkg.sv
// Shared types for the HyperBus delay-line reconfiguration sequencer.
package hyperbus_delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IDLE,
    GATE,
    SETTLE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hyperbus_delay_ctrl.sv
// Glitch-free tap switching for the HyperBus PHY clock delay line:
// wait for PHY idle, gate the line, change taps, settle, re-enable.
module hyperbus_delay_ctrl
  import hyperbus_delay_pkg::*;
#(
  parameter int DelayWidth   = 4,
  parameter int MaxDelay     = 2**DelayWidth-1,
  parameter int ResetDelay   = 0,
  parameter int GateCycles   = 2,
  parameter int SettleCycles = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [DelayWidth-1:0] cfg_delay_i,
  input  logic                  phy_idle_i,
  output logic                  delay_en_o,
  output logic [DelayWidth-1:0] delay_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  clamped_o
);

  typedef logic [DelayWidth-1:0] delay_t;

  localparam int CntWidth = $clog2(max_int(GateCycles, SettleCycles) + 1);
  typedef logic [CntWidth-1:0] cnt_t;

  localparam delay_t              RstTap     = delay_t'(ResetDelay);
  localparam logic [DelayWidth:0] MaxExt     = (DelayWidth+1)'(MaxDelay);
  localparam cnt_t                GateLoad   = cnt_t'(GateCycles - 1);
  localparam cnt_t                SettleLoad = cnt_t'(SettleCycles - 1);

  state_e state;
  delay_t pending;
  cnt_t   cnt;
  logic   accept;
  logic   over;
  delay_t req_tap;

  assign cfg_ready_o = (state == IDLE);
  assign accept      = cfg_valid_i && cfg_ready_o;
  // One extra bit keeps the range check meaningful when MaxDelay is the full tap range.
  assign over        = {1'b0, cfg_delay_i} > MaxExt;
  assign req_tap     = over ? MaxExt[DelayWidth-1:0] : cfg_delay_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pending    <= RstTap;
      cnt        <= '0;
      delay_o    <= RstTap;
      delay_en_o <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      clamped_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            pending   <= req_tap;
            clamped_o <= over;
            if (req_tap == delay_o) begin
              done_o <= 1'b1;
            end else begin
              state  <= WAIT_IDLE;
              busy_o <= 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (phy_idle_i) begin
            state      <= GATE;
            delay_en_o <= 1'b0;
            cnt        <= GateLoad;
          end
        end
        GATE: begin
          if (cnt == '0) begin
            delay_o <= pending;
            state   <= SETTLE;
            cnt     <= SettleLoad;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            delay_en_o <= 1'b1;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Randomized self-checking bench for hyperbus_delay_ctrl against a timeline model.
module tb_hyperbus_delay_ctrl;

  localparam int G     = 2;
  localparam int S     = 8;
  localparam int MAX_A = 15;
  localparam int MAX_C = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_ready, phy_idle;
  logic [3:0] cfg_delay, delay;
  logic       delay_en, busy, done, clamped;

  logic       cfg_valid_c, cfg_ready_c;
  logic [3:0] cfg_delay_c, delay_c;
  logic       delay_en_c, busy_c, done_c, clamped_c;

  int pass_cnt = 0;
  int total    = 0;
  int m_tap    = 0;
  int m_tap_c  = 0;
  bit m_clamp  = 1'b0;

  always #5 clk = ~clk;

  hyperbus_delay_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_delay_i(cfg_delay), .phy_idle_i(phy_idle), .delay_en_o(delay_en),
    .delay_o(delay), .busy_o(busy), .done_o(done), .clamped_o(clamped)
  );

  hyperbus_delay_ctrl #(.MaxDelay(MAX_C)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid_c), .cfg_ready_o(cfg_ready_c),
    .cfg_delay_i(cfg_delay_c), .phy_idle_i(phy_idle), .delay_en_o(delay_en_c),
    .delay_o(delay_c), .busy_o(busy_c), .done_o(done_c), .clamped_o(clamped_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    total++;
    if ({delay, delay_en, cfg_ready, busy, done, clamped} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state: got delay=%0d en=%b rdy=%b busy=%b done=%b clamp=%b, want 0 1 1 0 0 0",
               delay, delay_en, cfg_ready, busy, done, clamped);
    else pass_cnt++;
  endtask

  // Expected timeline: gate edge g = wait_n+1, en low over [g, g+G+S), tap changes at g+G.
  task automatic do_req(input string name, input int tap, input int wait_n,
                        input bit hold_next, input int next_tap);
    int  tgt, old, g, last, stop;
    bit  clp;
    logic [8:0] exp_v, act_v;
    clp = tap > MAX_A;
    tgt = clp ? MAX_A : tap;
    old = m_tap;
    cfg_valid = 1'b1;
    cfg_delay = 4'(tap);
    phy_idle  = 1'($urandom_range(0, 1));
    if (tgt == old) begin
      step();
      cfg_valid = 1'b0;
      m_clamp = clp;
      for (int k = 0; k < 3; k++) begin
        exp_v = {1'b1, 1'b0, (k == 0), 1'b1, 4'(old), m_clamp};
        act_v = {cfg_ready, busy, done, delay_en, delay, clamped};
        total++;
        if (act_v !== exp_v)
          $display("FAIL %s k=%0d: got rdy,busy,done,en,tap,clamp=%b want %b", name, k, act_v, exp_v);
        else pass_cnt++;
        step();
      end
      return;
    end
    g    = wait_n + 1;
    last = g + G + S;
    stop = hold_next ? last : last + 1;
    for (int k = 0; k <= stop; k++) begin
      step();
      if (k == 0) begin
        cfg_valid = hold_next;
        cfg_delay = 4'(next_tap);
        m_clamp   = clp;
      end
      exp_v = {(k >= last), (k < last), (k == last), !(k >= g && k < last),
               4'((k >= g + G) ? tgt : old), m_clamp};
      act_v = {cfg_ready, busy, done, delay_en, delay, clamped};
      total++;
      if (act_v !== exp_v)
        $display("FAIL %s k=%0d: got rdy,busy,done,en,tap,clamp=%b want %b", name, k, act_v, exp_v);
      else pass_cnt++;
      if (k + 1 < g) phy_idle = 1'b0;
      else if (k + 1 == g) phy_idle = 1'b1;
      else phy_idle = 1'($urandom_range(0, 1));
    end
    m_tap = tgt;
  endtask

  task automatic test_basic();
    do_req("basic_tap5", 5, 0, 1'b0, 0);
  endtask

  task automatic test_same_tap();
    do_req("same_tap", m_tap, 0, 1'b0, 0);
  endtask

  task automatic test_wait_idle();
    do_req("wait_idle", 9, 20, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    do_req("b2b_first", 12, 1, 1'b1, 3);
    do_req("b2b_second", 3, 2, 1'b0, 0);
  endtask

  task automatic test_random();
    int tap;
    for (int i = 0; i < 10; i++) begin
      tap = (i == 4) ? m_tap : int'($urandom_range(0, 15));
      do_req("random", tap, int'($urandom_range(0, 4)), 1'b0, 0);
    end
  endtask

  task automatic test_clamp();
    int t_exp;
    phy_idle    = 1'b1;
    cfg_valid_c = 1'b1;
    cfg_delay_c = 4'd15;
    step();
    cfg_valid_c = 1'b0;
    total++;
    if ({clamped_c, busy_c} !== 2'b11)
      $display("FAIL clamp_accept: got clamped=%b busy=%b want 1 1", clamped_c, busy_c);
    else pass_cnt++;
    repeat (1 + G + S) step();
    t_exp = MAX_C;
    total++;
    if ({delay_c, delay_en_c, done_c, clamped_c} !== {4'(t_exp), 1'b1, 1'b1, 1'b1})
      $display("FAIL clamp_done: got tap=%0d en=%b done=%b clamped=%b want %0d 1 1 1",
               delay_c, delay_en_c, done_c, clamped_c, t_exp);
    else pass_cnt++;
    m_tap_c = t_exp;
    cfg_valid_c = 1'b1;
    cfg_delay_c = 4'd3;
    step();
    cfg_valid_c = 1'b0;
    total++;
    if (clamped_c !== 1'b0)
      $display("FAIL clamp_clear: got clamped=%b want 0", clamped_c);
    else pass_cnt++;
    repeat (1 + G + S) step();
    total++;
    if ({delay_c, done_c} !== {4'd3, 1'b1})
      $display("FAIL clamp_inrange: got tap=%0d done=%b want 3 1", delay_c, done_c);
    else pass_cnt++;
    m_tap_c = 3;
  endtask

  task automatic test_reset_mid();
    int tap;
    tap = (m_tap == 7) ? 11 : 7;
    cfg_valid = 1'b1;
    cfg_delay = 4'(tap);
    phy_idle  = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (6) step();
    total++;
    if ({delay_en, delay, busy} !== {1'b0, 4'(tap), 1'b1})
      $display("FAIL mid_settle: got en=%b tap=%0d busy=%b want 0 %0d 1", delay_en, delay, busy, tap);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({delay, delay_en, busy, done, cfg_ready} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL async_reset: got tap=%0d en=%b busy=%b done=%b rdy=%b want 0 1 0 0 1",
               delay, delay_en, busy, done, cfg_ready);
    else pass_cnt++;
    step();
    step();
    #2 rst_n = 1'b1;
    m_tap = 0; m_tap_c = 0; m_clamp = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      phy_idle = 1'($urandom_range(0, 1));
      total++;
      if ({done, delay_en, delay, busy} !== {1'b0, 1'b1, 4'd0, 1'b0})
        $display("FAIL post_reset k=%0d: got done=%b en=%b tap=%0d busy=%b want 0 1 0 0",
                 k, done, delay_en, delay, busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_delay   = '0;
    phy_idle    = 1'b0;
    cfg_valid_c = 1'b0;
    cfg_delay_c = '0;
    #12 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_same_tap();
    test_wait_idle();
    test_back_to_back();
    test_random();
    test_clamp();
    test_reset_mid();
    do_req("after_reset", 6, 1, 1'b0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
